// File: rtl/fir_coef_sequencer_if.sv
// Signal bundle between fir_coef_sequencer and its environment (host streams plus FIR tap port).
// The slave modport is the sequencer's view; master is the host/FIR side.
interface fir_coef_sequencer_if #(
    parameter int COEF_W = 8,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 20
);
    logic              load_start;
    logic              coef_in_valid;
    logic [COEF_W-1:0] coef_in;
    logic              coef_in_ready;
    logic              sample_in_valid;
    logic [DATA_W-1:0] sample_in;
    logic              sample_in_ready;
    logic              fir_coef_write_enable;
    logic [IDX_W-1:0]  fir_coef_number;
    logic [COEF_W-1:0] fir_coef_value;
    logic [DATA_W-1:0] fir_input_data;
    logic [OUT_W-1:0]  fir_output_data;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              busy;
    logic              load_done;

    modport slave (
        input  load_start,
        input  coef_in_valid,
        input  coef_in,
        output coef_in_ready,
        input  sample_in_valid,
        input  sample_in,
        output sample_in_ready,
        output fir_coef_write_enable,
        output fir_coef_number,
        output fir_coef_value,
        output fir_input_data,
        input  fir_output_data,
        output out_valid,
        output out_data,
        output busy,
        output load_done
    );

    modport master (
        output load_start,
        output coef_in_valid,
        output coef_in,
        input  coef_in_ready,
        output sample_in_valid,
        output sample_in,
        input  sample_in_ready,
        input  fir_coef_write_enable,
        input  fir_coef_number,
        input  fir_coef_value,
        input  fir_input_data,
        output fir_output_data,
        input  out_valid,
        input  out_data,
        input  busy,
        input  load_done
    );
endinterface

// File: rtl/fir_coef_sequencer.sv
// Sequencer for a reset-less 5-tap FIR: loads a coefficient burst, flushes the delay line with
// zeros, then streams samples and tags each result with a valid flag aligned to the FIR latency.
module fir_coef_sequencer #(
    parameter int NTAPS   = 5,
    parameter int COEF_W  = 8,
    parameter int IDX_W   = 4,
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 20,
    parameter int FIR_LAT = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    fir_coef_sequencer_if.slave bus
);
    localparam int TAG_DEPTH = 1 + FIR_LAT;
    localparam int CNT_W     = $clog2(NTAPS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;

    logic                 coef_we_q, coef_we_d;
    logic [IDX_W-1:0]     coef_number_q, coef_number_d;
    logic [COEF_W-1:0]    coef_value_q, coef_value_d;
    logic [DATA_W-1:0]    input_data_q, input_data_d;
    logic                 busy_q, busy_d;
    logic                 load_done_q, load_done_d;
    logic                 out_valid_q, out_valid_d;

    logic                 coef_fire;
    logic                 sample_fire;

    // load_start masks both readies so a beat in the restart cycle is never half-accepted.
    assign bus.coef_in_ready   = (state_q == LOAD) && !bus.load_start;
    assign bus.sample_in_ready = (state_q == RUN)  && !bus.load_start;

    assign coef_fire   = bus.coef_in_valid   && bus.coef_in_ready;
    assign sample_fire = bus.sample_in_valid && bus.sample_in_ready;

    assign bus.fir_coef_write_enable = coef_we_q;
    assign bus.fir_coef_number       = coef_number_q;
    assign bus.fir_coef_value        = coef_value_q;
    assign bus.fir_input_data        = input_data_q;
    assign bus.busy                  = busy_q;
    assign bus.load_done             = load_done_q;
    assign bus.out_valid             = out_valid_q;
    assign bus.out_data              = bus.fir_output_data;

    always_comb begin
        // NOTE: every _d signal gets a default before any branch; a path that skips an
        // assignment in always_comb would otherwise infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        flush_cnt_d   = flush_cnt_q;
        tag_d         = tag_q << 1;
        tag_d[0]      = sample_fire;
        coef_we_d     = 1'b0;
        coef_number_d = coef_number_q;
        coef_value_d  = coef_value_q;
        input_data_d  = '0;
        load_done_d   = 1'b0;
        out_valid_d   = tag_q[TAG_DEPTH-1];

        if (bus.load_start) begin
            state_d     = LOAD;
            idx_d       = '0;
            flush_cnt_d = '0;
            tag_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    if (coef_fire) begin
                        coef_we_d     = 1'b1;
                        coef_number_d = idx_q;
                        coef_value_d  = bus.coef_in;
                        idx_d         = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d     = FLUSH;
                            flush_cnt_d = '0;
                        end
                    end
                end
                FLUSH: begin
                    // input_data_d stays 0, shifting zeros through every delay-line stage.
                    if (flush_cnt_q == LAST_FLUSH) begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                        load_done_d = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // A missing sample still advances the FIR, so a zero bubble is fed in.
                    if (sample_fire) begin
                        input_data_d = bus.sample_in;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == LOAD) || (state_d == FLUSH);
    end

    // NOTE: state and outputs update with non-blocking assignments so every flop samples the
    // pre-edge values; the tag pipeline is reset too, otherwise stale tags could raise out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            flush_cnt_q   <= '0;
            tag_q         <= '0;
            coef_we_q     <= 1'b0;
            coef_number_q <= '0;
            coef_value_q  <= '0;
            input_data_q  <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            flush_cnt_q   <= flush_cnt_d;
            tag_q         <= tag_d;
            coef_we_q     <= coef_we_d;
            coef_number_q <= coef_number_d;
            coef_value_q  <= coef_value_d;
            input_data_q  <= input_data_d;
            busy_q        <= busy_d;
            load_done_q   <= load_done_d;
            out_valid_q   <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed bench for fir_coef_sequencer with a behavioural 5-tap FIR (no reset, FIR_LAT=1)
// attached to its coefficient/data port; expected results are hand-computed constants.
module tb_fir_coef_sequencer;
    localparam int NTAPS   = 5;
    localparam int COEF_W  = 8;
    localparam int IDX_W   = 4;
    localparam int DATA_W  = 8;
    localparam int OUT_W   = 20;
    localparam int FIR_LAT = 1;
    localparam int LAT     = 1 + FIR_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fir_coef_sequencer_if #(.COEF_W(COEF_W), .IDX_W(IDX_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    fir_coef_sequencer #(
        .NTAPS(NTAPS), .COEF_W(COEF_W), .IDX_W(IDX_W),
        .DATA_W(DATA_W), .OUT_W(OUT_W), .FIR_LAT(FIR_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural FIR: coefficient write and delay-line capture at the edge, output one edge later.
    logic [COEF_W-1:0] fir_coef [NTAPS] = '{default: '0};
    logic [DATA_W-1:0] fir_dl   [NTAPS] = '{default: '0};
    logic [OUT_W-1:0]  fir_out = '0;

    function automatic logic [OUT_W-1:0] fir_sum();
        logic [OUT_W-1:0] acc = '0;
        for (int i = 0; i < NTAPS; i++) acc += OUT_W'(fir_coef[i]) * OUT_W'(fir_dl[i]);
        return acc;
    endfunction

    always @(posedge clk) begin
        if (bus.fir_coef_write_enable && (bus.fir_coef_number < IDX_W'(NTAPS)))
            fir_coef[3'(bus.fir_coef_number)] <= bus.fir_coef_value;
        fir_dl[0] <= bus.fir_input_data;
        for (int i = 1; i < NTAPS; i++) fir_dl[i] <= fir_dl[i-1];
        fir_out <= fir_sum();
    end

    assign bus.fir_output_data = fir_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.load_start      = 1'b0;
        bus.coef_in_valid   = 1'b0;
        bus.coef_in         = '0;
        bus.sample_in_valid = 1'b0;
        bus.sample_in       = '0;
    endtask

    // Full back-to-back reload; returns in the first RUN cycle (load_done high).
    task automatic do_load(input logic [NTAPS-1:0][COEF_W-1:0] c);
        int t;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            bus.coef_in_valid = 1'b1;
            bus.coef_in       = c[i];
            tick();
        end
        bus.coef_in_valid = 1'b0;
        t = 0;
        while (!bus.load_done && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (bus.load_done !== 1'b1) $display("FAIL load_done_timeout: got load_done=%0b after %0d cycles, want 1", bus.load_done, t);
        else n_pass++;
    endtask

    task automatic test_reset();
        int blocked;
        drive_idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.coef_in_ready, bus.sample_in_ready, bus.fir_coef_write_enable,
             bus.busy, bus.load_done, bus.out_valid} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {bus.coef_in_ready, bus.sample_in_ready,
                     bus.fir_coef_write_enable, bus.busy, bus.load_done, bus.out_valid});
        else n_pass++;
        n_checks++;
        if (bus.fir_coef_number !== '0 || bus.fir_coef_value !== '0 || bus.fir_input_data !== '0)
            $display("FAIL reset_fir_port: got num=%0d val=%0d in=%0d want 0 0 0",
                     bus.fir_coef_number, bus.fir_coef_value, bus.fir_input_data);
        else n_pass++;
        n_checks++;
        if (bus.out_data !== '0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.sample_in_valid = 1'b1;
        bus.sample_in       = 8'h55;
        blocked = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.sample_in_ready !== 1'b0 || bus.fir_input_data !== '0) blocked++;
        end
        n_checks++;
        if (blocked != 0) $display("FAIL idle_sample_block: got %0d cycles with ready/data set, want 0", blocked);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", bus.busy);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_back_to_back();
        int busy_cnt, done_cnt;
        bus.load_start = 1'b1;
        #1;
        n_checks++;
        if (bus.coef_in_ready !== 1'b0) $display("FAIL b2b_ready_at_start: got %0b want 0", bus.coef_in_ready);
        else n_pass++;
        tick();
        bus.load_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < NTAPS; i++) begin
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.load_done);
            bus.coef_in_valid = 1'b1;
            bus.coef_in       = COEF_W'(i + 1);
            tick();
            n_checks++;
            if (bus.fir_coef_write_enable !== 1'b1 || bus.fir_coef_number !== IDX_W'(i) ||
                bus.fir_coef_value !== COEF_W'(i + 1))
                $display("FAIL b2b_write%0d: got we=%0b num=%0d val=%0d want 1 %0d %0d", i,
                         bus.fir_coef_write_enable, bus.fir_coef_number, bus.fir_coef_value, i, i + 1);
            else n_pass++;
        end
        bus.coef_in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.load_done);
            tick();
        end
        n_checks++;
        if (busy_cnt != 2 * NTAPS) $display("FAIL b2b_busy_cycles: got %0d want %0d", busy_cnt, 2 * NTAPS);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL b2b_load_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (bus.sample_in_ready !== 1'b1) $display("FAIL b2b_run_ready: got %0b want 1", bus.sample_in_ready);
        else n_pass++;
    endtask

    task automatic test_gapped_load();
        logic [NTAPS-1:0][COEF_W-1:0] c;
        logic [3:0][OUT_W-1:0] exp_out;
        int wr_cnt, t;
        logic exp_v;
        c = '0;
        c[0] = 8'd2;
        exp_out = '0;
        exp_out[0] = 20'd2;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < NTAPS; i++) begin
            bus.coef_in_valid = 1'b1;
            bus.coef_in       = c[i];
            tick();
            wr_cnt += int'(bus.fir_coef_write_enable);
            n_checks++;
            if (bus.fir_coef_write_enable !== 1'b1 || bus.fir_coef_number !== IDX_W'(i) || bus.fir_coef_value !== c[i])
                $display("FAIL gap_write%0d: got we=%0b num=%0d val=%0d want 1 %0d %0d", i,
                         bus.fir_coef_write_enable, bus.fir_coef_number, bus.fir_coef_value, i, c[i]);
            else n_pass++;
            bus.coef_in_valid = 1'b0;
            bus.coef_in       = 8'hEE;
            tick();
            wr_cnt += int'(bus.fir_coef_write_enable);
            n_checks++;
            if (bus.fir_coef_write_enable !== 1'b0) $display("FAIL gap_idle_we%0d: got %0b want 0", i, bus.fir_coef_write_enable);
            else n_pass++;
        end
        t = 0;
        while (!bus.load_done && t < 20) begin
            tick();
            wr_cnt += int'(bus.fir_coef_write_enable);
            t++;
        end
        n_checks++;
        if (bus.load_done !== 1'b1) $display("FAIL gap_load_done_timeout: got %0b want 1", bus.load_done);
        else n_pass++;
        n_checks++;
        if (wr_cnt != NTAPS) $display("FAIL gap_write_count: got %0d want %0d", wr_cnt, NTAPS);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
            bus.sample_in_valid = (j < 4);
            bus.sample_in       = (j == 0) ? 8'd1 : 8'd0;
            tick();
            exp_v = (j >= LAT) && (j < LAT + 4);
            n_checks++;
            if (bus.out_valid !== exp_v) $display("FAIL impulse_valid%0d: got %0b want %0b", j, bus.out_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if (bus.out_data !== exp_out[j-LAT])
                    $display("FAIL impulse_data%0d: got %0d want %0d", j, bus.out_data, exp_out[j-LAT]);
                else n_pass++;
            end
        end
        drive_idle();
    endtask

    task automatic test_bubbles();
        logic [NTAPS-1:0][COEF_W-1:0] c;
        logic [6:0] exp_v;
        for (int i = 0; i < NTAPS; i++) c[i] = 8'd1;
        exp_v = 7'b0010100;
        do_load(c);
        for (int j = 0; j < 7; j++) begin
            bus.sample_in_valid = (j == 0) || (j == 2);
            bus.sample_in       = (j == 0) ? 8'd3 : ((j == 2) ? 8'd4 : 8'd0);
            tick();
            n_checks++;
            if (bus.out_valid !== exp_v[j]) $display("FAIL bubble_valid%0d: got %0b want %0b", j, bus.out_valid, exp_v[j]);
            else n_pass++;
            if (j == 2) begin
                n_checks++;
                if (bus.out_data !== 20'd3) $display("FAIL bubble_data_first: got %0d want 3", bus.out_data);
                else n_pass++;
            end
            if (j == 4) begin
                n_checks++;
                if (bus.out_data !== 20'd7) $display("FAIL bubble_data_after_gap: got %0d want 7", bus.out_data);
                else n_pass++;
            end
        end
        drive_idle();
    endtask

    task automatic test_reload_mid_stream();
        int t;
        bus.sample_in_valid = 1'b1;
        bus.sample_in       = 8'd5;
        tick();
        bus.sample_in       = 8'd6;
        tick();
        bus.load_start = 1'b1;
        bus.sample_in  = 8'd7;
        #1;
        n_checks++;
        if (bus.sample_in_ready !== 1'b0) $display("FAIL reload_sample_ready: got %0b want 0", bus.sample_in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reload_out_valid_drop: got %0b want 0", bus.out_valid);
        else n_pass++;
        bus.load_start      = 1'b0;
        bus.sample_in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.coef_in_ready !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL reload_in_load: got ready=%0b busy=%0b want 1 1", bus.coef_in_ready, bus.busy);
        else n_pass++;
        bus.coef_in_valid = 1'b1;
        bus.coef_in       = 8'd1;
        tick();
        n_checks++;
        if (bus.fir_coef_write_enable !== 1'b1 || bus.fir_coef_number !== '0 || bus.out_valid !== 1'b0)
            $display("FAIL reload_first_idx: got we=%0b num=%0d out_valid=%0b want 1 0 0",
                     bus.fir_coef_write_enable, bus.fir_coef_number, bus.out_valid);
        else n_pass++;
        bus.coef_in = 8'd0;
        for (int i = 1; i < NTAPS; i++) tick();
        bus.coef_in_valid = 1'b0;
        t = 0;
        while (!bus.load_done && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (bus.load_done !== 1'b1) $display("FAIL reload_load_done_timeout: got %0b want 1", bus.load_done);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_restart_in_load();
        logic [NTAPS-1:0][COEF_W-1:0] c;
        logic [NTAPS-1:0][OUT_W-1:0] exp_out;
        logic exp_v;
        int t;
        c[0] = 8'd3; c[1] = 8'd1; c[2] = 8'd4; c[3] = 8'd1; c[4] = 8'd5;
        for (int i = 0; i < NTAPS; i++) exp_out[i] = OUT_W'(c[i]);
        bus.load_start = 1'b1;
        tick();
        bus.load_start    = 1'b0;
        bus.coef_in_valid = 1'b1;
        bus.coef_in       = 8'd9;
        for (int i = 0; i < 3; i++) tick();
        bus.load_start = 1'b1;
        bus.coef_in    = 8'd8;
        #1;
        n_checks++;
        if (bus.coef_in_ready !== 1'b0) $display("FAIL restart_ready: got %0b want 0", bus.coef_in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.fir_coef_write_enable !== 1'b0) $display("FAIL restart_beat_dropped: got we=%0b want 0", bus.fir_coef_write_enable);
        else n_pass++;
        bus.load_start = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            bus.coef_in = c[i];
            tick();
            if (i == 0) begin
                n_checks++;
                if (bus.fir_coef_write_enable !== 1'b1 || bus.fir_coef_number !== '0 || bus.fir_coef_value !== c[0])
                    $display("FAIL restart_idx0: got we=%0b num=%0d val=%0d want 1 0 %0d",
                             bus.fir_coef_write_enable, bus.fir_coef_number, bus.fir_coef_value, c[0]);
                else n_pass++;
            end
            if (i == NTAPS - 2) begin
                n_checks++;
                if (bus.coef_in_ready !== 1'b1) $display("FAIL restart_still_load: got ready=%0b want 1", bus.coef_in_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus.coef_in_ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL restart_flush_entry: got ready=%0b busy=%0b want 0 1", bus.coef_in_ready, bus.busy);
        else n_pass++;
        bus.coef_in_valid = 1'b0;
        t = 0;
        while (!bus.load_done && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (bus.load_done !== 1'b1) $display("FAIL restart_load_done_timeout: got %0b want 1", bus.load_done);
        else n_pass++;
        for (int j = 0; j < NTAPS + LAT + 1; j++) begin
            bus.sample_in_valid = (j < NTAPS);
            bus.sample_in       = (j == 0) ? 8'd1 : 8'd0;
            tick();
            exp_v = (j >= LAT) && (j < LAT + NTAPS);
            n_checks++;
            if (bus.out_valid !== exp_v) $display("FAIL restart_imp_valid%0d: got %0b want %0b", j, bus.out_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if (bus.out_data !== exp_out[j-LAT])
                    $display("FAIL restart_imp_data%0d: got %0d want %0d", j, bus.out_data, exp_out[j-LAT]);
                else n_pass++;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_load();
        logic [NTAPS-1:0][COEF_W-1:0] c;
        int blocked;
        for (int i = 0; i < NTAPS; i++) c[i] = COEF_W'(i);
        bus.load_start = 1'b1;
        tick();
        bus.load_start    = 1'b0;
        bus.coef_in_valid = 1'b1;
        bus.coef_in       = 8'd7;
        tick();
        tick();
        bus.coef_in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.coef_in_ready !== 1'b0 || bus.fir_coef_write_enable !== 1'b0 || bus.fir_coef_number !== '0)
            $display("FAIL midload_reset: got busy=%0b ready=%0b we=%0b num=%0d want 0 0 0 0",
                     bus.busy, bus.coef_in_ready, bus.fir_coef_write_enable, bus.fir_coef_number);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.sample_in_valid = 1'b1;
        bus.sample_in       = 8'd9;
        blocked = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.sample_in_ready !== 1'b0 || bus.coef_in_ready !== 1'b0) blocked++;
        end
        n_checks++;
        if (blocked != 0) $display("FAIL midload_blocked: got %0d cycles with a ready set, want 0", blocked);
        else n_pass++;
        bus.sample_in_valid = 1'b0;
        do_load(c);
        n_checks++;
        if (bus.sample_in_ready !== 1'b1) $display("FAIL midload_reload_ready: got %0b want 1", bus.sample_in_ready);
        else n_pass++;
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_back_to_back();
        test_gapped_load();
        test_bubbles();
        test_reload_mid_stream();
        test_restart_in_load();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_coef_sequencer.md
# fir_coef_sequencer

Control front-end for the 5-tap FIR datapath (`FIR_filter_b` port set: `coef_write_enable`, `coef_number`, `coef_value`, `input_data`, `output_data`). It accepts a coefficient burst from a host over a valid/ready handshake and writes it into the FIR tap registers one per cycle. It then flushes the FIR delay line with zeros and streams samples through, tagging each result with a valid flag. The filter itself has no reset and no flow control, so this block owns all of its sequencing.

## Interface
- `NTAPS`, 5, number of FIR coefficients and delay-line depth
- `COEF_W`, 8, coefficient width
- `IDX_W`, 4, coefficient index width (must satisfy 2^IDX_W ≥ NTAPS)
- `DATA_W`, 8, sample width
- `OUT_W`, 20, FIR result width
- `FIR_LAT`, 1, clock edges from FIR `input_data` capture to matching `output_data`

- `clk` in 1 — single clock; all state updates on the rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `load_start` in 1 — single-cycle request to begin a coefficient reload
- `coef_in_valid` in 1 / `coef_in` in COEF_W / `coef_in_ready` out 1 — coefficient stream, sent in index order 0..NTAPS-1
- `sample_in_valid` in 1 / `sample_in` in DATA_W / `sample_in_ready` out 1 — sample stream
- `fir_coef_write_enable` out 1, `fir_coef_number` out IDX_W, `fir_coef_value` out COEF_W — drive the FIR coefficient port
- `fir_input_data` out DATA_W — drives the FIR `input_data` port
- `fir_output_data` in OUT_W — from the FIR `output_data` port
- `out_valid` out 1 / `out_data` out OUT_W — filtered result stream; no backpressure
- `busy` out 1 — high in LOAD and FLUSH
- `load_done` out 1 — one-cycle pulse on entry to RUN

## Operation
- States: IDLE, LOAD, FLUSH, RUN. Reset enters IDLE.
- IDLE
  - All readies are 0. `fir_input_data` is 0.
  - `load_start` moves to LOAD and clears the index to 0.
- LOAD
  - `coef_in_ready`=1.
  - Each handshake (`coef_in_valid` & ready) registers one write: we=1, number=idx, value=`coef_in`. Then idx++.
  - The handshake with idx=NTAPS-1 moves to FLUSH.
  - Gaps in `coef_in_valid` are allowed. While waiting, we=0.
- FLUSH
  - Drives `fir_input_data`=0 for exactly NTAPS cycles, tracked by a flush counter.
  - Then moves to RUN and pulses `load_done`.
- RUN
  - `sample_in_ready`=1.
  - On each cycle, `fir_input_data` is registered as `sample_in` if `sample_in_valid`, otherwise 0 (a bubble).
  - A valid-tag pipeline of depth 1+FIR_LAT tracks each accepted sample to its matching result.
  - `out_data` = `fir_output_data` (combinational pass-through). `out_valid` = tag delayed by 1+FIR_LAT.
- `load_start` in RUN or FLUSH: moves to LOAD, clears idx and the tag pipeline, and drops `out_valid` the next cycle.
- `load_start` in LOAD: restarts at idx=0. A beat presented in the same cycle is not accepted; ready is 0 for that cycle.
- `load_start` takes priority over all other events in the same cycle.

## Timing
- Reset values (asynchronous):
  - state IDLE; idx 0; flush counter 0; tag pipeline 0.
  - `coef_in_ready`, `sample_in_ready`, `fir_coef_write_enable`, `busy`, `load_done`, `out_valid` all 0.
  - `fir_coef_number`, `fir_coef_value`, `fir_input_data` all 0.
- Ready generation:
  - Readies are decoded combinationally from the registered state.
  - In the cycle `load_start` is high, both readies are forced to 0.
- Coefficient write latency:
  - A beat accepted at edge k appears on the FIR coefficient port during cycle k→k+1.
  - The FIR captures it at edge k+1.
- Load duration:
  - Back-to-back beats give a minimum LOAD of NTAPS cycles, followed by NTAPS FLUSH cycles.
  - `load_done` is high in the first RUN cycle.
- Sample latency: a sample accepted at edge k produces `out_valid`=1 in the cycle after edge k+1+FIR_LAT.
- Width rules:
  - `out_data` is the raw FIR result, with no truncation.
  - idx wraps are impossible; the state leaves LOAD at NTAPS-1.
- Reset asserted mid-LOAD:
  - The FIR keeps its partial coefficients, but the block returns to IDLE.
  - Samples are blocked until a full reload completes.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles, released mid-cycle.
  - All outputs are 0 and the state is IDLE.
  - `sample_in_ready` stays 0 for 20 cycles with `sample_in_valid`=1.
- **Back-to-back load:** `load_start`, then coefs 1,2,3,4,5 on consecutive cycles.
  - `fir_coef_number` steps 0..4 with we=1 on 5 consecutive cycles.
  - `busy` is high for 10 cycles.
  - `load_done` pulses once.
- **Gapped load:** coefs 2,0,0,0,0 with `coef_in_valid` low every other cycle.
  - Exactly 5 writes occur, with we=0 in the gaps.
  - A subsequent impulse stream 1,0,0,0 gives `out_data` 2,0,0,0 with `out_valid` aligned per FIR_LAT.
- **Bubbles in RUN:** coefs 1,1,1,1,1; samples 3,_,4 (the middle cycle is invalid).
  - `out_valid` pattern is 1,0,1.
  - The result for sample 4 is 7, because the bubble inserts a 0.
- **Reload mid-stream:** `load_start` during RUN with samples in flight.
  - `out_valid` is 0 from the next cycle.
  - `sample_in_ready` is 0 in the same cycle.
  - LOAD restarts at idx 0.
- **Restart within LOAD:** `load_start` again after 3 beats.
  - The next accepted beat writes `fir_coef_number`=0.
  - FLUSH begins only after 5 more beats.
